// File: rtl/spi_frontend_pkg.sv
// spi_frontend_pkg: shared types and constants for the SPI register front end
// Contents: FSM state enum, mode bit positions, synchronizer depth.
package spi_frontend_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        ADDR,
        DATA,
        DRAIN
    } spi_fe_state_t;

    localparam int MODE_CPOL_BIT = 1;
    localparam int MODE_CPHA_BIT = 0;
    localparam int SYNC_STAGES   = 2;

endpackage

// File: rtl/spi_reg_frontend_if.sv
// spi_reg_frontend_if: SPI pins plus register-bank access signals
// Signals: spi_cs_n, spi_clk, spi_mosi, spi_miso (SPI side);
//          wr_rdn, addr, wdata, rdata, we (register bank side).
// Modports: slave = the front end, master = SPI master plus register bank.
interface spi_reg_frontend_if #(
    parameter int ADDR_W = 4,
    parameter int REG_W  = 8
);
    logic              spi_cs_n;
    logic              spi_clk;
    logic              spi_mosi;
    logic              spi_miso;
    logic              wr_rdn;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [REG_W-1:0]  wdata;
    logic [REG_W-1:0]  rdata;

    modport slave (
        input  spi_cs_n, spi_clk, spi_mosi, rdata,
        output spi_miso, wr_rdn, addr, wdata, we
    );

    modport master (
        output spi_cs_n, spi_clk, spi_mosi, rdata,
        input  spi_miso, wr_rdn, addr, wdata, we
    );
endinterface

// File: rtl/spi_pin_sync.sv
// spi_pin_sync: N-FF synchronizer for an asynchronous pin with optional edge pulses
// Ports: clk, rstb (async, active-low), d (raw pin), q (synchronized level),
//        rise/fall (one-cycle registered pulses, tied low when EDGES=0).
module spi_pin_sync
    import spi_frontend_pkg::*;
#(
    parameter int STAGES  = SYNC_STAGES,
    parameter bit RST_VAL = 1'b0,
    parameter bit EDGES   = 1'b1
) (
    input  logic clk,
    input  logic rstb,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);
    logic [STAGES-1:0] s;

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) s <= {STAGES{RST_VAL}};
        else       s <= {s[STAGES-2:0], d};
    end

    assign q = s[STAGES-1];

    if (EDGES) begin : g_edge
        logic prev;
        // Registered pulses: one extra cycle after the synchronized level changes.
        always_ff @(posedge clk or negedge rstb) begin
            if (!rstb) begin
                prev <= RST_VAL;
                rise <= 1'b0;
                fall <= 1'b0;
            end else begin
                prev <= q;
                rise <= q & ~prev;
                fall <= ~q & prev;
            end
        end
    end else begin : g_noedge
        assign rise = 1'b0;
        assign fall = 1'b0;
    end

endmodule

// File: rtl/spi_reg_frontend.sv
// spi_reg_frontend: oversampled SPI target turning a cs_n-framed transaction into a register access
// Ports: clk, rstb (async, active-low), ena (low forces IDLE), mode ([1]=CPOL, [0]=CPHA),
//        bus (slave modport: SPI pins, wr_rdn/addr/wdata/we outputs, rdata input).
// Frame: command bit, ADDR_W address bits, REG_W data bits, MSB first.
// Option: define SPI_ADDR_AUTOINC_EN for address auto-increment over consecutive words.
module spi_reg_frontend
    import spi_frontend_pkg::*;
#(
    parameter int ADDR_W = 4,
    parameter int REG_W  = 8
) (
    input  logic       clk,
    input  logic       rstb,
    input  logic       ena,
    input  logic [1:0] mode,
    spi_reg_frontend_if.slave bus
);
    localparam int MAX_W = (ADDR_W > REG_W) ? ADDR_W : REG_W;
    localparam int CNT_W = $clog2(MAX_W + 1);
    localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_W - 1);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(REG_W - 1);

    spi_fe_state_t     state, state_n;
    logic [CNT_W-1:0]  cnt, cnt_n;
    logic              sclk_rise, sclk_fall, cs_rise, cs_fall, mosi;
    logic              unused_sclk, unused_cs, unused_mosi_rise, unused_mosi_fall;
    logic              lead, trail, sample, shift, abort, smp;
    logic              addr_done, word_done;
    logic              cmd, load, miso_q;
    logic              wr_rdn_q, we_q;
    logic [ADDR_W-1:0] addr_sh, addr_q;
    logic [REG_W-1:0]  rx_sh, tx_sh, wdata_q;

    // cs_n chain resets low so a select already held across reset never looks like a fresh fall.
    spi_pin_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0), .EDGES(1'b1)) u_cs (
        .clk(clk), .rstb(rstb), .d(bus.spi_cs_n), .q(unused_cs), .rise(cs_rise), .fall(cs_fall)
    );
    spi_pin_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0), .EDGES(1'b1)) u_sclk (
        .clk(clk), .rstb(rstb), .d(bus.spi_clk), .q(unused_sclk), .rise(sclk_rise), .fall(sclk_fall)
    );
    spi_pin_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0), .EDGES(1'b0)) u_mosi (
        .clk(clk), .rstb(rstb), .d(bus.spi_mosi), .q(mosi), .rise(unused_mosi_rise), .fall(unused_mosi_fall)
    );

    assign lead   = mode[MODE_CPOL_BIT] ? sclk_fall : sclk_rise;
    assign trail  = mode[MODE_CPOL_BIT] ? sclk_rise : sclk_fall;
    assign sample = mode[MODE_CPHA_BIT] ? trail : lead;
    assign shift  = mode[MODE_CPHA_BIT] ? lead : trail;
    // A cs_n rise in the same cycle as a sample edge discards the sample.
    assign abort  = cs_rise | ~ena;
    assign smp    = sample & ~abort;

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        addr_done = 1'b0;
        word_done = 1'b0;
        if (abort) state_n = IDLE;
        else begin
            case (state)
                IDLE: if (cs_fall) state_n = CMD;
                CMD:  if (smp) state_n = ADDR;
                ADDR: if (smp) begin
                    if (cnt == ADDR_LAST) begin
                        state_n   = DATA;
                        addr_done = 1'b1;
                    end else cnt_n = cnt + CNT_W'(1);
                end
                DATA: if (smp) begin
                    if (cnt == DATA_LAST) begin
                        word_done = 1'b1;
                        cnt_n     = '0;
`ifdef SPI_ADDR_AUTOINC_EN
                        state_n   = DATA;
`else
                        state_n   = DRAIN;
`endif
                    end else cnt_n = cnt + CNT_W'(1);
                end
                default: ;
            endcase
        end
        if (state_n != state) cnt_n = '0;
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            cmd      <= 1'b0;
            load     <= 1'b0;
            miso_q   <= 1'b0;
            addr_sh  <= '0;
            rx_sh    <= '0;
            tx_sh    <= '0;
            wr_rdn_q <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            we_q     <= 1'b0;
        end else begin
            we_q <= 1'b0;
            load <= 1'b0;
            if (smp && state == CMD)  cmd     <= mosi;
            if (smp && state == ADDR) addr_sh <= {addr_sh[ADDR_W-2:0], mosi};
            if (smp && state == DATA) rx_sh   <= {rx_sh[REG_W-2:0], mosi};
            if (addr_done) begin
                addr_q   <= {addr_sh[ADDR_W-2:0], mosi};
                wr_rdn_q <= cmd;
                load     <= ~cmd;
                miso_q   <= 1'b0;
            end
            if (word_done && wr_rdn_q) begin
                wdata_q <= {rx_sh[REG_W-2:0], mosi};
                we_q    <= 1'b1;
            end
`ifdef SPI_ADDR_AUTOINC_EN
            if (word_done) begin
                addr_q <= addr_q + ADDR_W'(1);
                load   <= ~wr_rdn_q;
            end
`endif
            // rdata follows addr combinationally, so it is captured one cycle after addr moves.
            if (load) tx_sh <= bus.rdata;
            else if (shift && state == DATA && !wr_rdn_q) begin
                miso_q <= tx_sh[REG_W-1];
                tx_sh  <= {tx_sh[REG_W-2:0], 1'b0};
            end
        end
    end

    assign bus.spi_miso = miso_q & (state == DATA) & ~wr_rdn_q;
    assign bus.wr_rdn   = wr_rdn_q;
    assign bus.addr     = addr_q;
    assign bus.wdata    = wdata_q;
    assign bus.we       = we_q;

endmodule

// File: tb/tb_spi_reg_frontend.sv
// tb_spi_reg_frontend: scoreboard bench for spi_reg_frontend (ADDR_W=4, REG_W=8)
// Expected writes and read bits are queued when a frame is issued and popped as the DUT responds.
module tb_spi_reg_frontend;
    import spi_frontend_pkg::*;

    localparam int HP = 8;

    typedef struct {
        logic [3:0] a;
        logic [7:0] d;
    } wr_t;

    logic       clk = 1'b0;
    logic       rstb = 1'b0;
    logic       ena = 1'b1;
    logic [1:0] mode = 2'b00;
    int         checks = 0;
    int         errors = 0;
    wr_t        wq[$];
    logic       mq[$];
    logic [7:0] regs [16];
    logic       we_prev = 1'b0;
    logic       ena_viol = 1'b0;
    logic [7:0] last_wdata;
    wr_t        e;

    spi_reg_frontend_if #(.ADDR_W(4), .REG_W(8)) bus ();

    spi_reg_frontend #(.ADDR_W(4), .REG_W(8)) dut (
        .clk(clk), .rstb(rstb), .ena(ena), .mode(mode), .bus(bus.slave)
    );

    always #5 clk = ~clk;

    assign bus.rdata = regs[bus.addr];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic chk_reset(input string p);
        chk({p, "_miso"}, 32'(bus.spi_miso), 0);
        chk({p, "_wr_rdn"}, 32'(bus.wr_rdn), 0);
        chk({p, "_addr"}, 32'(bus.addr), 0);
        chk({p, "_wdata"}, 32'(bus.wdata), 0);
        chk({p, "_we"}, 32'(bus.we), 0);
        chk({p, "_state"}, 32'(dut.state), 32'(IDLE));
    endtask

    // One frame of n bits (bits[n-1] first); optionally reset mid-frame instead of deselecting.
    task automatic frame(input logic [1:0] m, input logic [63:0] bits, input int n, input bit rst_mid);
        mode = m;
        bus.spi_clk = m[1];
        repeat (HP) @(negedge clk);
        bus.spi_cs_n = 1'b0;
        repeat (HP) @(negedge clk);
        for (int i = n - 1; i >= 0; i--) begin
            if (m[0]) bus.spi_clk = ~m[1];
            bus.spi_mosi = bits[i];
            repeat (HP) @(negedge clk);
            if (n - 1 - i >= 5 && mq.size() > 0) chk("miso", 32'(bus.spi_miso), 32'(mq.pop_front()));
            bus.spi_clk = m[0] ? m[1] : ~m[1];
            repeat (HP) @(negedge clk);
            if (!m[0]) bus.spi_clk = m[1];
        end
        if (rst_mid) begin
            rstb = 1'b0;
            repeat (3) @(negedge clk);
            rstb = 1'b1;
            repeat (2) @(negedge clk);
        end else begin
            repeat (HP) @(negedge clk);
            bus.spi_cs_n = 1'b1;
        end
        repeat (2 * HP) @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (bus.we) begin
            chk("we_width", 32'({we_prev, bus.we}), 32'b01);
            if (wq.size() == 0) chk("we_unexp", 32'(wq.size()), 1);
            else begin
                e = wq.pop_front();
                chk("we_addr", 32'(bus.addr), 32'(e.a));
                chk("we_data", 32'(bus.wdata), 32'(e.d));
                chk("we_wr", 32'(bus.wr_rdn), 1);
            end
        end
        we_prev = bus.we;
        if (!ena && (dut.state != IDLE || bus.spi_miso)) ena_viol = 1'b1;
    end

    initial begin
        repeat (50000) @(posedge clk);
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.spi_cs_n = 1'b1;
        bus.spi_clk  = 1'b0;
        bus.spi_mosi = 1'b0;
        for (int i = 0; i < 16; i++) regs[i] = 8'(i * 17);
        regs[9] = 8'h3C;
        repeat (4) @(negedge clk);
        chk_reset("rst");
        rstb = 1'b1;
        repeat (4) @(negedge clk);

        // Mode 0 write 1,0011,A5
        wq.push_back('{4'h3, 8'hA5});
        frame(2'b00, 64'({1'b1, 4'h3, 8'hA5}), 13, 1'b0);
        chk("t1_pending", 32'(wq.size()), 0);
        chk("t1_addr", 32'(bus.addr), 3);
        chk("t1_wdata", 32'(bus.wdata), 32'h A5);
        chk("t1_wr", 32'(bus.wr_rdn), 1);

        // Mode 3 read of address 9
        for (int i = 7; i >= 0; i--) mq.push_back(regs[9][i]);
        frame(2'b11, 64'({1'b0, 4'h9, 8'h00}), 13, 1'b0);
        chk("t2_bits_left", 32'(mq.size()), 0);
        chk("t2_addr", 32'(bus.addr), 9);
        chk("t2_wr", 32'(bus.wr_rdn), 0);
        chk("t2_wdata", 32'(bus.wdata), 32'h A5);

        // Mode 1 write FF, then a frame aborted after 6 data bits
        wq.push_back('{4'h0, 8'hFF});
        frame(2'b01, 64'({1'b1, 4'h0, 8'hFF}), 13, 1'b0);
        chk("t3_pending", 32'(wq.size()), 0);
        frame(2'b01, 64'({1'b1, 4'h6, 6'b101010}), 11, 1'b0);
        chk("t3_abort_wdata", 32'(bus.wdata), 32'h FF);
        chk("t3_abort_addr", 32'(bus.addr), 6);
        chk("t3_abort_state", 32'(dut.state), 32'(IDLE));

        // Reset in the middle of the address phase, then a normal frame
        frame(2'b00, 64'(3'b101), 3, 1'b1);
        chk_reset("mid");
        bus.spi_cs_n = 1'b1;
        repeat (2 * HP) @(negedge clk);
        wq.push_back('{4'h5, 8'h5A});
        frame(2'b00, 64'({1'b1, 4'h5, 8'h5A}), 13, 1'b0);
        chk("t4_pending", 32'(wq.size()), 0);
        chk("t4_wdata", 32'(bus.wdata), 32'h 5A);

        // Two data words starting at address 15
        wq.push_back('{4'hF, 8'h11});
`ifdef SPI_ADDR_AUTOINC_EN
        wq.push_back('{4'h0, 8'h22});
        last_wdata = 8'h22;
`else
        last_wdata = 8'h11;
`endif
        frame(2'b00, 64'({1'b1, 4'hF, 8'h11, 8'h22}), 21, 1'b0);
        chk("t5_pending", 32'(wq.size()), 0);
        chk("t5_wdata", 32'(bus.wdata), 32'(last_wdata));

        // Disabled block ignores a complete write frame
        ena = 1'b0;
        ena_viol = 1'b0;
        frame(2'b00, 64'({1'b1, 4'h2, 8'h77}), 13, 1'b0);
        chk("t6_active", 32'(ena_viol), 0);
        chk("t6_wdata", 32'(bus.wdata), 32'(last_wdata));
        chk("t6_pending", 32'(wq.size()), 0);
        ena = 1'b1;
        repeat (4) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
